// File: rtl/goldschmidt_pkg.sv
// Shared types and Q16.16 constants for the Goldschmidt divider controller.
package goldschmidt_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned FRAC_W      = 16;
  localparam int unsigned NORM_BIT    = FRAC_W - 1;
  localparam int unsigned POS_W       = 5;
  localparam int unsigned SHIFT_W     = 6;
  localparam int unsigned ITER_W      = 4;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned DEF_ITER    = 4;
  localparam int unsigned DEF_MUL_LAT = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    FCALC = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Signed shift that moves the leading one to NORM_BIT (positive = right).
  function automatic logic [SHIFT_W-1:0] norm_shift_of(input logic [POS_W-1:0] pos);
    return SHIFT_W'({1'b0, pos}) - SHIFT_W'(NORM_BIT);
  endfunction

endpackage

// File: rtl/lead_one_enc.sv
// 32-bit leading-one priority encoder with an all-zero flag.
module lead_one_enc
  import goldschmidt_pkg::*;
(
  input  logic [WORD_W-1:0] d,
  output logic [POS_W-1:0]  pos,
  output logic              zero
);

  // Highest set bit wins; pos is 0 when d is all zero.
  always_comb begin
    pos = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      if (d[i]) pos = POS_W'(i);
    end
  end

  assign zero = (d == '0);

endmodule

// File: rtl/goldschmidt_ctrl.sv
// Sequencing controller for the Goldschmidt fixed-point divider datapath.
module goldschmidt_ctrl
  import goldschmidt_pkg::*;
#(
  parameter int unsigned ITER    = DEF_ITER,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        ld_in,
  output logic        ld_norm,
  output logic [5:0]  norm_shift,
  output logic        ld_f,
  output logic        mul_en,
  output logic        ld_nd,
  output logic [3:0]  iter
);

  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(ITER - 1);
  localparam logic [CNT_W-1:0]  LAT_LAST  = CNT_W'(MUL_LAT - 1);

  state_t              state_q, state_n;
  logic [ITER_W-1:0]   iter_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                flag_q, flag_n;
  logic [WORD_W-1:0]   div_q, div_n;
  logic [SHIFT_W-1:0]  shift_n;
  logic                busy_n, done_n, div_zero_n;
  logic                ld_norm_n, ld_f_n, mul_en_n, ld_nd_n;

  logic [WORD_W-1:0]   enc_in;
  logic [POS_W-1:0]    lead_pos;
  logic                enc_zero;

  // Encoder looks at the live operand while idle, the latched copy afterwards.
  assign enc_in = (state_q == IDLE) ? divisor : div_q;

  lead_one_enc u_enc (
    .d    (enc_in),
    .pos  (lead_pos),
    .zero (enc_zero)
  );

  // Operand load strobe follows start directly so N/D capture in the accept cycle.
  assign ld_in = (state_q == IDLE) && start && !reset;

  // Next-state, bookkeeping and next-cycle output decode.
  always_comb begin
    state_n = state_q;
    iter_n  = iter;
    cnt_n   = cnt_q;
    flag_n  = flag_q;
    div_n   = div_q;
    shift_n = norm_shift;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (enc_zero) begin
            flag_n  = 1'b1;
            shift_n = '0;
            state_n = DONE;
          end else begin
            div_n   = divisor;
            shift_n = norm_shift_of(lead_pos);
            state_n = NORM;
          end
        end
      end
      NORM: begin
        shift_n = norm_shift_of(lead_pos);
        state_n = FCALC;
      end
      FCALC: begin
        cnt_n   = '0;
        state_n = MUL;
      end
      MUL: begin
        if (cnt_q == LAT_LAST) begin
          if (iter == ITER_LAST) begin
            state_n = DONE;
          end else begin
            iter_n  = iter + ITER_W'(1);
            state_n = FCALC;
          end
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        iter_n  = '0;
        cnt_n   = '0;
        flag_n  = 1'b0;
        div_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n     = (state_n != IDLE);
    done_n     = (state_n == DONE);
    div_zero_n = (state_n == DONE) && flag_n;
    ld_norm_n  = (state_n == NORM);
    ld_f_n     = (state_n == FCALC);
    mul_en_n   = (state_n == MUL);
    ld_nd_n    = (state_n == MUL) && (cnt_n == LAT_LAST);
  end

  // State, counters and registered datapath controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      iter       <= '0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      div_q      <= '0;
      norm_shift <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      ld_norm    <= 1'b0;
      ld_f       <= 1'b0;
      mul_en     <= 1'b0;
      ld_nd      <= 1'b0;
    end else begin
      state_q    <= state_n;
      iter       <= iter_n;
      cnt_q      <= cnt_n;
      flag_q     <= flag_n;
      div_q      <= div_n;
      norm_shift <= shift_n;
      busy       <= busy_n;
      done       <= done_n;
      div_zero   <= div_zero_n;
      ld_norm    <= ld_norm_n;
      ld_f       <= ld_f_n;
      mul_en     <= mul_en_n;
      ld_nd      <= ld_nd_n;
    end
  end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Self-checking bench for goldschmidt_ctrl against a cycle-offset reference model.
module tb_goldschmidt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset0, start0, reset1, start1;
  logic [31:0] divisor0, divisor1;
  logic        busy0, done0, dz0, ld_in0, ld_norm0, ld_f0, mul_en0, ld_nd0;
  logic        busy1, done1, dz1, ld_in1, ld_norm1, ld_f1, mul_en1, ld_nd1;
  logic [5:0]  sh0, sh1;
  logic [3:0]  it0, it1;

  goldschmidt_ctrl #(.ITER(4), .MUL_LAT(2)) u_dut0 (
    .clk(clk), .reset(reset0), .start(start0), .divisor(divisor0),
    .busy(busy0), .done(done0), .div_zero(dz0), .ld_in(ld_in0),
    .ld_norm(ld_norm0), .norm_shift(sh0), .ld_f(ld_f0), .mul_en(mul_en0),
    .ld_nd(ld_nd0), .iter(it0)
  );

  goldschmidt_ctrl #(.ITER(1), .MUL_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset1), .start(start1), .divisor(divisor1),
    .busy(busy1), .done(done1), .div_zero(dz1), .ld_in(ld_in1),
    .ld_norm(ld_norm1), .norm_shift(sh1), .ld_f(ld_f1), .mul_en(mul_en1),
    .ld_nd(ld_nd1), .iter(it1)
  );

  int checks = 0;
  int errors = 0;
  int opn    = 0;
  logic [5:0] hold [2];
  bit         hold_known [2];

  // Layout: busy done div_zero ld_in ld_norm ld_f mul_en ld_nd iter[4] shift[6]
  function automatic logic [17:0] obs_vec(input int sel);
    if (sel == 0)
      return {busy0, done0, dz0, ld_in0, ld_norm0, ld_f0, mul_en0, ld_nd0, it0, sh0};
    return {busy1, done1, dz1, ld_in1, ld_norm1, ld_f1, mul_en1, ld_nd1, it1, sh1};
  endfunction

  // Reference: outputs as a function of cycle offset k from acceptance.
  function automatic logic [17:0] exp_vec(input int k, input int ni, input int lat,
                                          input bit zero, input logic [5:0] sh,
                                          input logic [5:0] prev_sh);
    int d, r, j, itv;
    bit b, dn, dzv, li, ln, lf, me, lnd;
    logic [5:0] s;
    d   = zero ? 1 : 2 + ni * (1 + lat);
    b   = (k >= 1) && (k <= d);
    dn  = (k == d);
    dzv = zero && (k == d);
    li  = (k == 0);
    ln  = !zero && (k == 1);
    lf  = 1'b0; me = 1'b0; lnd = 1'b0; itv = 0;
    if (!zero && k >= 2 && k < d) begin
      r   = (k - 2) % (lat + 1);
      j   = (k - 2) / (lat + 1);
      lf  = (r == 0);
      me  = (r != 0);
      lnd = (r == lat);
      itv = j;
    end
    if (!zero && k == d) itv = ni - 1;
    s = (k == 0) ? prev_sh : sh;
    return {b, dn, dzv, li, ln, lf, me, lnd, 4'(itv), s};
  endfunction

  // Leading-one position minus 15, found by scanning down from the MSB.
  function automatic logic [5:0] ref_shift(input logic [31:0] dv);
    int p;
    p = 0;
    for (int b = 31; b >= 0; b--) begin
      if (dv[b]) begin
        p = b;
        break;
      end
    end
    return 6'(p - 15);
  endfunction

  task automatic drive(input int sel, input bit rst, input bit st, input logic [31:0] dv);
    if (sel == 0) begin
      reset0 = rst; start0 = st; divisor0 = dv;
    end else begin
      reset1 = rst; start1 = st; divisor1 = dv;
    end
  endtask

  task automatic step(input int sel, input bit rst, input bit st, input logic [31:0] dv);
    @(posedge clk);
    #1;
    drive(sel, rst, st, dv);
    @(negedge clk);
  endtask

  task automatic check(input int sel, input string tag, input logic [17:0] exp_in, input bit mask_sh);
    logic [17:0] o, e;
    o = obs_vec(sel);
    e = exp_in;
    if (mask_sh) begin
      o[5:0] = '0;
      e[5:0] = '0;
    end
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One idle cycle; st must be 0 unless rst is high.
  task automatic idle_step(input int sel, input bit rst, input bit st);
    logic [17:0] e;
    step(sel, rst, st, $urandom);
    e = {3'b000, st && !rst, 4'b0000, 4'd0, hold[sel]};
    check(sel, $sformatf("idle%0d r%0d s%0d", sel, rst, st), e, !hold_known[sel]);
    if (rst) begin
      hold[sel]       = '0;
      hold_known[sel] = 1'b1;
    end
  endtask

  // mode 0: single start pulse; 1: start held; 2: random start noise while busy.
  task automatic run_op(input int sel, input logic [31:0] dv, input int mode,
                        input int ni, input int lat, input logic [5:0] sh, input int abort_k);
    bit zero, st, rst, mask;
    int d, last;
    logic [31:0] dvk;
    zero = (dv == 32'd0);
    d    = zero ? 1 : 2 + ni * (1 + lat);
    last = (abort_k >= 0) ? abort_k : d;
    opn++;
    for (int k = 0; k <= last; k++) begin
      st   = (k == 0) ? 1'b1 : (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      rst  = (k == abort_k);
      dvk  = (k == 0) ? dv : $urandom;
      step(sel, rst, st, dvk);
      mask = (zero && k > 0) || (k == 0 && !hold_known[sel]);
      check(sel, $sformatf("op%0d dv=%h k%0d", opn, dv, k),
            exp_vec(k, ni, lat, zero, sh, hold[sel]), mask);
    end
    if (abort_k >= 0) begin
      hold[sel] = '0; hold_known[sel] = 1'b1;
    end else if (zero) begin
      hold_known[sel] = 1'b0;
    end else begin
      hold[sel] = sh; hold_known[sel] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] dv;
    int md;
    reset0 = 1'b1; start0 = 1'b0; divisor0 = '0;
    reset1 = 1'b1; start1 = 1'b0; divisor1 = '0;
    hold[0] = '0; hold[1] = '0;
    hold_known[0] = 1'b1; hold_known[1] = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state and reset-over-start priority.
    idle_step(0, 1'b1, 1'b1);
    idle_step(0, 1'b0, 1'b0);
    idle_step(1, 1'b1, 1'b0);
    idle_step(1, 1'b0, 1'b0);

    // Directed normalisation cases.
    run_op(0, 32'h0003_0000, 0, 4, 2, 6'd2, -1);
    idle_step(0, 1'b0, 1'b0);
    run_op(0, 32'h0000_4000, 2, 4, 2, 6'h3F, -1);
    idle_step(0, 1'b0, 1'b0);
    run_op(0, 32'h8000_0000, 0, 4, 2, 6'd16, -1);
    idle_step(0, 1'b0, 1'b0);
    run_op(0, 32'h0000_0001, 2, 4, 2, 6'h31, -1);
    idle_step(0, 1'b0, 1'b0);

    // Divide by zero, alone and back-to-back with a real operation.
    run_op(0, 32'h0000_0000, 2, 4, 2, 6'd0, -1);
    idle_step(0, 1'b0, 1'b0);
    run_op(0, 32'h0000_0000, 1, 4, 2, 6'd0, -1);
    run_op(0, 32'h0005_0000, 0, 4, 2, 6'd3, -1);
    idle_step(0, 1'b0, 1'b0);

    // Start held high: one acceptance per operation, next in the cycle after DONE.
    run_op(0, 32'h0003_0000, 1, 4, 2, 6'd2, -1);
    run_op(0, 32'h0005_0000, 1, 4, 2, 6'd3, -1);
    idle_step(0, 1'b0, 1'b0);

    // Abort during MUL, new start accepted in the very next cycle.
    run_op(0, 32'h0003_0000, 0, 4, 2, 6'd2, 6);
    run_op(0, 32'h0001_2345, 0, 4, 2, ref_shift(32'h0001_2345), -1);
    idle_step(0, 1'b0, 1'b0);

    // Minimal configuration instance.
    run_op(1, 32'h0003_0000, 0, 1, 1, 6'd2, -1);
    idle_step(1, 1'b0, 1'b0);
    run_op(1, 32'h0000_0000, 0, 1, 1, 6'd0, -1);
    idle_step(1, 1'b0, 1'b0);
    run_op(1, 32'h0000_4000, 2, 1, 1, 6'h3F, -1);
    idle_step(1, 1'b0, 1'b0);

    // Randomized operands and start noise.
    for (int n = 0; n < 12; n++) begin
      dv = $urandom >> $urandom_range(0, 31);
      if (n == 4) dv = 32'd0;
      md = int'($urandom_range(0, 2));
      run_op(0, dv, md, 4, 2, ref_shift(dv), -1);
      idle_step(0, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_step(0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
